alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Responder side of the ALU operation interface. It accepts operation requests (op, a, b) over a valid/ready handshake, executes them, and returns a registered result with flags over a second valid/ready handshake. Single-cycle ops complete in 1 cycle. MUL runs as an iterative shift-add over WIDTH cycles. It sits between the instruction issue logic and the register writeback path.

Parameters:
WIDTH, 16, operand/result width in bits
OP_W, 4, opcode width

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_op  input  OP_W  opcode
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_result  output  WIDTH  result
rsp_carry  output  1  carry/no-borrow flag
rsp_zero  output  1  result == 0
rsp_err  output  1  illegal opcode
busy  output  1  multiply in progress

Behaviour:
- Reset (async, reset_n low): state=IDLE, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0, busy=0, counter=0. A reset during MUL or while a result is held discards that operation.
- Opcodes: 0 ADD, 1 OR, 2 AND, 3 SUB (a-b), 4 XOR, 5 SHL (a<<b[3:0]), 6 SHR logical (a>>b[3:0]), 7 MUL (low WIDTH bits of a*b, unsigned), 8-15 illegal.
- Arithmetic is modulo 2^WIDTH.
- rsp_carry: ADD = carry-out; SUB = 1 when a>=b unsigned (no borrow); all other ops = 0.
- rsp_zero = (rsp_result==0). It is valid for every op, including MUL.
- Illegal op: result=0, rsp_err=1, rsp_zero=1, latency 1.
- req_ready = (state==IDLE) && (!rsp_valid || rsp_ready). The unit accepts in the same cycle a held result drains.
- Accept = req_valid && req_ready. Request fields are sampled only on accept.
- States:
  - IDLE. On accept of a non-MUL op, register the result and flags and set rsp_valid=1 at that edge (latency 1). On accept of MUL, load mcand=a, mplier=b, acc=0, cnt=0, set busy=1, go to MUL.
  - MUL. Each cycle: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++. On the edge where cnt==WIDTH-1, write the final acc to rsp_result, set flags, rsp_valid=1, busy=0, state=IDLE. The result is visible WIDTH cycles after the accept edge. req_ready=0 throughout.
- Result hold: while rsp_valid && !rsp_ready, rsp_* hold stable and no new result is written.
- rsp_valid && rsp_ready with no new accept: rsp_valid drops at the next edge and rsp_result keeps its last value.
- Simultaneous rsp handshake and new accept: the new result replaces the old one and rsp_valid stays 1, giving back-to-back throughput of 1 op/cycle for non-MUL ops.
- MUL finishing while the previous result is still held cannot occur: MUL is only accepted when the output slot is free or draining.
- Inputs change while not accepted: no effect.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_MUL), OP_ILLEGAL_MIN=8, state encoding (ST_IDLE, ST_MUL), default WIDTH.
- One sub-module, alu_iter_mul: start/operands in, done/product out, cnt and shift registers internal.
- The single-cycle datapath stays inline as a combinational case.

Test Plan:
- ADD 0xFFFF+0x0001, rsp_ready=1 -> next cycle rsp_valid=1, result=0x0000, carry=1, zero=1, err=0.
- SUB 0x0000-0x0001 -> result=0xFFFF, carry=0. Then SUB 5-5 -> result=0, carry=1, zero=1.
- MUL 0x0012*0x0034 accepted at cycle t -> busy=1 and req_ready=0 for cycles t+1..t+16; rsp_valid=1 at t+16 with result=0x03A8. Also MUL 0x1234*0x0100 -> 0x3400.
- Backpressure: OR 0x00F0|0x000F with rsp_ready=0 for 5 cycles -> result=0x00FF held stable, req_ready=0. When rsp_ready=1, AND 0xFF00&0x0FF0 is accepted the same cycle -> next result=0x0F00, rsp_valid never drops.
- Illegal op 9 -> result=0, err=1, zero=1. SHL 0x0001 by b=0x0013 (uses b[3:0]=3) -> 0x0008.
- Assert reset_n=0 mid-MUL (cycle t+7) -> all outputs 0 immediately, state IDLE. After release, req_ready=1 and ADD 2+3 returns 5 one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit.
//   - default datapath and opcode widths
//   - opcode encodings (OP_ADD .. OP_MUL) and the first illegal opcode
//   - control state encoding for the execution unit
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_OP_W  = 4;

  localparam logic [3:0] OP_ADD         = 4'd0;
  localparam logic [3:0] OP_OR          = 4'd1;
  localparam logic [3:0] OP_AND         = 4'd2;
  localparam logic [3:0] OP_SUB         = 4'd3;
  localparam logic [3:0] OP_XOR         = 4'd4;
  localparam logic [3:0] OP_SHL         = 4'd5;
  localparam logic [3:0] OP_SHR         = 4'd6;
  localparam logic [3:0] OP_MUL         = 4'd7;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : load operands and begin (ignored bits of a*b above WIDTH)
//   a, b           : multiplicand / multiplier, sampled on start
//   done           : high during the last iteration cycle; product is valid then
//   product        : final accumulator value (includes the last partial product)
module alu_iter_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = active && (cnt == CNT_LAST);
  // The final iteration's partial product is folded in combinationally so
  // the result can be captured on the same edge the count expires.
  assign product  = acc_next;

  // Iteration control
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        active <= 1'b0;
      end
    end
  end

  // Shift-add datapath
  always_ff @(posedge clock) begin
    if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts (op, a, b) over a valid/ready request channel
// and returns a registered result with carry/zero/err flags over a
// valid/ready response channel. Non-MUL ops take one cycle; MUL iterates
// for WIDTH cycles in alu_iter_mul.
// Ports:
//   clock, reset_n              : clock and asynchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_op, req_a, req_b        : request fields, sampled on accept
//   rsp_valid/rsp_ready         : response handshake
//   rsp_result, rsp_carry,
//   rsp_zero, rsp_err           : registered result and flags
//   busy                        : multiply in progress
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OP_W  = DEFAULT_OP_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  logic [0:0]       state;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_err;
  logic [3:0]       shamt;

  assign req_ready = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign is_mul    = (req_op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign busy      = (state == ST_MUL);
  assign shamt     = req_b[3:0];

  // Single-cycle datapath
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = (req_op >= OP_ILLEGAL_MIN);
    case (req_op)
      OP_ADD:  {alu_carry, alu_res} = {1'b0, req_a} + {1'b0, req_b};
      OP_OR:   alu_res = req_a | req_b;
      OP_AND:  alu_res = req_a & req_b;
      OP_SUB: begin
        alu_res   = req_a - req_b;
        alu_carry = (req_a >= req_b);
      end
      OP_XOR:  alu_res = req_a ^ req_b;
      OP_SHL:  alu_res = req_a << shamt;
      OP_SHR:  alu_res = req_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  alu_iter_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (req_a),
    .b       (req_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Response register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      // A drained result drops valid unless a new result overwrites it below.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_result <= alu_res;
              rsp_carry  <= alu_carry;
              rsp_zero   <= (alu_res == '0);
              rsp_err    <= alu_err;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b1;
            rsp_result <= mul_product;
            rsp_carry  <= 1'b0;
            rsp_zero   <= (mul_product == '0);
            rsp_err    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int WIDTH = 16;
  localparam int OP_W  = 4;

  logic             clock;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;

  int vectors;
  int miscompares;

  alu_exec_unit #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed observation: {rsp_valid, result[15:0], carry, zero, err, busy, req_ready}
  function automatic logic [21:0] obs();
    return {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, busy, req_ready};
  endfunction

  function automatic logic [21:0] mk(input logic v, input logic [15:0] r,
                                     input logic c, input logic z, input logic e,
                                     input logic b, input logic rr);
    return {v, r, c, z, e, b, rr};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request and advance through its accept edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_op    = 4'hF;
    req_a     = 16'hDEAD;
    req_b     = 16'hBEEF;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    #1;
    vectors++;
    if (obs() !== mk(0, 16'h0000, 0, 0, 0, 0, 1)) begin
      $display("FAIL reset_state: got %h expected %h", obs(), mk(0, 16'h0000, 0, 0, 0, 0, 1));
      miscompares++;
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    issue(4'd0, 16'hFFFF, 16'h0001);
    vectors++;
    if (obs() !== mk(1, 16'h0000, 1, 1, 0, 0, 1)) begin
      $display("FAIL add_wrap: got %h expected %h", obs(), mk(1, 16'h0000, 1, 1, 0, 0, 1));
      miscompares++;
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000) begin
      $display("FAIL add_drain: got valid=%b result=%h expected valid=0 result=0000", rsp_valid, rsp_result);
      miscompares++;
    end
  endtask

  task automatic test_sub();
    issue(4'd3, 16'h0000, 16'h0001);
    vectors++;
    if (obs() !== mk(1, 16'hFFFF, 0, 0, 0, 0, 1)) begin
      $display("FAIL sub_borrow: got %h expected %h", obs(), mk(1, 16'hFFFF, 0, 0, 0, 0, 1));
      miscompares++;
    end
    issue(4'd3, 16'h0005, 16'h0005);
    vectors++;
    if (obs() !== mk(1, 16'h0000, 1, 1, 0, 0, 1)) begin
      $display("FAIL sub_equal: got %h expected %h", obs(), mk(1, 16'h0000, 1, 1, 0, 0, 1));
      miscompares++;
    end
    tick();
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int busy_bad;
    busy_bad = 0;
    issue(4'd7, a, b);
    // Samples after the accept edge and the next 15 edges: still computing.
    for (int i = 0; i < WIDTH; i++) begin
      if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) busy_bad++;
      tick();
    end
    vectors++;
    if (busy_bad != 0) begin
      $display("FAIL mul_busy_window: got %0d bad cycles expected 0", busy_bad);
      miscompares++;
    end
    vectors++;
    if (obs() !== mk(1, exp, 0, (exp == 16'h0), 0, 0, 1)) begin
      $display("FAIL mul_result: got %h expected %h", obs(), mk(1, exp, 0, (exp == 16'h0), 0, 0, 1));
      miscompares++;
    end
    tick();
  endtask

  task automatic test_mul();
    run_mul(16'h0012, 16'h0034, 16'h03A8);
    run_mul(16'h1234, 16'h0100, 16'h3400);
  endtask

  task automatic test_backpressure();
    int hold_bad;
    hold_bad  = 0;
    rsp_ready = 1'b0;
    issue(4'd1, 16'h00F0, 16'h000F);
    // A competing request is presented while the result is held.
    req_valid = 1'b1;
    req_op    = 4'd2;
    req_a     = 16'hFF00;
    req_b     = 16'h0FF0;
    for (int i = 0; i < 5; i++) begin
      if (obs() !== mk(1, 16'h00FF, 0, 0, 0, 0, 0)) hold_bad++;
      tick();
    end
    vectors++;
    if (hold_bad != 0) begin
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad);
      miscompares++;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      $display("FAIL bp_ready_on_drain: got %b expected 1", req_ready);
      miscompares++;
    end
    tick();
    req_valid = 1'b0;
    vectors++;
    if (obs() !== mk(1, 16'h0F00, 0, 0, 0, 0, 1)) begin
      $display("FAIL bp_replace: got %h expected %h", obs(), mk(1, 16'h0F00, 0, 0, 0, 0, 1));
      miscompares++;
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 16'h0F00) begin
      $display("FAIL bp_drop_keep: got valid=%b result=%h expected valid=0 result=0f00", rsp_valid, rsp_result);
      miscompares++;
    end
  endtask

  task automatic test_illegal_and_shift();
    issue(4'd9, 16'h1234, 16'h5678);
    vectors++;
    if (obs() !== mk(1, 16'h0000, 0, 1, 1, 0, 1)) begin
      $display("FAIL illegal_op: got %h expected %h", obs(), mk(1, 16'h0000, 0, 1, 1, 0, 1));
      miscompares++;
    end
    issue(4'd5, 16'h0001, 16'h0013);
    vectors++;
    if (obs() !== mk(1, 16'h0008, 0, 0, 0, 0, 1)) begin
      $display("FAIL shl_mask: got %h expected %h", obs(), mk(1, 16'h0008, 0, 0, 0, 0, 1));
      miscompares++;
    end
    issue(4'd6, 16'h8000, 16'h000F);
    vectors++;
    if (obs() !== mk(1, 16'h0001, 0, 0, 0, 0, 1)) begin
      $display("FAIL shr_logical: got %h expected %h", obs(), mk(1, 16'h0001, 0, 0, 0, 0, 1));
      miscompares++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [15:0] as  [3];
    logic [15:0] bs  [3];
    logic [21:0] exp [3];
    ops[0] = 4'd0; as[0] = 16'h0001; bs[0] = 16'h0002; exp[0] = mk(1, 16'h0003, 0, 0, 0, 0, 1);
    ops[1] = 4'd4; as[1] = 16'hA5A5; bs[1] = 16'hFFFF; exp[1] = mk(1, 16'h5A5A, 0, 0, 0, 0, 1);
    ops[2] = 4'd3; as[2] = 16'h000A; bs[2] = 16'h0003; exp[2] = mk(1, 16'h0007, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_op    = ops[i];
      req_a     = as[i];
      req_b     = bs[i];
      tick();
      vectors++;
      if (obs() !== exp[i]) begin
        $display("FAIL b2b_%0d: got %h expected %h", i, obs(), exp[i]);
        miscompares++;
      end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    stray = 0;
    issue(4'd7, 16'h0012, 16'h0034);
    for (int i = 0; i < 7; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== mk(0, 16'h0000, 0, 0, 0, 0, 1)) begin
      $display("FAIL reset_mid_mul: got %h expected %h", obs(), mk(0, 16'h0000, 0, 0, 0, 0, 1));
      miscompares++;
    end
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ready_after_reset: got %b expected 1", req_ready);
      miscompares++;
    end
    issue(4'd0, 16'h0002, 16'h0003);
    vectors++;
    if (obs() !== mk(1, 16'h0005, 0, 0, 0, 0, 1)) begin
      $display("FAIL add_after_reset: got %h expected %h", obs(), mk(1, 16'h0005, 0, 0, 0, 0, 1));
      miscompares++;
    end
    // The discarded multiply must never surface later.
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      $display("FAIL discarded_mul: got %0d stray cycles expected 0", stray);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_illegal_and_shift();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
